// File: rtl/z_result_stage_if.sv
// Z result stage bundle: ALU result/flags in, Z register, read bus and status out.
// Optional overflow signals exist only when ZREG_OVF_FLAG_EN is defined.
interface z_result_stage_if #(
    parameter int DATA_W = 32
);
    logic [2*DATA_W-1:0] ALUOut_in;
    logic                Zero_in;
    logic [3:0]          ALUControl_in;
    logic                cap_start;
    logic                Zlowout;
    logic                Zhighout;
    logic [DATA_W-1:0]   bus_out;
    logic [DATA_W-1:0]   ZLow_q;
    logic [DATA_W-1:0]   ZHigh_q;
    logic                busy;
    logic                z_valid;
    logic                flag_Z;
    logic                flag_N;
    logic                rd_conflict;
`ifdef ZREG_OVF_FLAG_EN
    logic                A_sign;
    logic                B_sign;
    logic                flag_V;
`endif

    modport master (
        output ALUOut_in,
        output Zero_in,
        output ALUControl_in,
        output cap_start,
        output Zlowout,
        output Zhighout,
`ifdef ZREG_OVF_FLAG_EN
        output A_sign,
        output B_sign,
        input  flag_V,
`endif
        input  bus_out,
        input  ZLow_q,
        input  ZHigh_q,
        input  busy,
        input  z_valid,
        input  flag_Z,
        input  flag_N,
        input  rd_conflict
    );

    modport slave (
        input  ALUOut_in,
        input  Zero_in,
        input  ALUControl_in,
        input  cap_start,
        input  Zlowout,
        input  Zhighout,
`ifdef ZREG_OVF_FLAG_EN
        input  A_sign,
        input  B_sign,
        output flag_V,
`endif
        output bus_out,
        output ZLow_q,
        output ZHigh_q,
        output busy,
        output z_valid,
        output flag_Z,
        output flag_N,
        output rd_conflict
    );
endinterface

// File: rtl/z_result_stage.sv
// Z result stage: settle window, capture of the ALU result into ZHigh:ZLow, read mux.
// Define ZREG_OVF_FLAG_EN to add A_sign/B_sign inputs and the flag_V overflow output.
module z_result_stage #(
    parameter int SETTLE_CYCLES = 3,
    parameter int DATA_W        = 32
) (
    input logic             clock,
    input logic             clear,
    z_result_stage_if.slave zif
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1010;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("z_result_stage: SETTLE_CYCLES must be within 1..15");
    end

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              do_capture;

    logic [DATA_W-1:0] zlow;
    logic [DATA_W-1:0] zhigh;
    logic              flag_z;
    logic              flag_n;
    logic              z_valid;
    logic              rd_conflict;

    logic [DATA_W-1:0] zlow_d;
    logic [DATA_W-1:0] zhigh_d;
    logic              flag_n_d;

    // State register and settle counter
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: any cap_start restarts the settle window, abandoning a pending capture
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        do_capture = 1'b0;
        if (zif.cap_start) begin
            state_nxt = SETTLE;
            cnt_nxt   = CNT_INIT;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                SETTLE: begin
                    if (cnt == 4'd0) begin
                        state_nxt = CAPTURE;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    do_capture = 1'b1;
                    state_nxt  = HOLD;
                end
                HOLD: begin
                    state_nxt = HOLD;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Opcode-dependent mapping of the ALU result onto ZHigh:ZLow and the sign flag
    always_comb begin
        zlow_d   = zif.ALUOut_in[DATA_W-1:0];
        zhigh_d  = '0;
        flag_n_d = zif.ALUOut_in[DATA_W-1];
        unique case (zif.ALUControl_in)
            OP_MUL: begin
                zhigh_d  = zif.ALUOut_in[2*DATA_W-1:DATA_W];
                flag_n_d = zif.ALUOut_in[2*DATA_W-1];
            end
            OP_DIV: begin
                zhigh_d  = zif.ALUOut_in[2*DATA_W-1:DATA_W];
            end
            default: begin
                zhigh_d  = '0;
            end
        endcase
    end

    // Z register, flags, valid and registered read-conflict pulse
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            zlow        <= '0;
            zhigh       <= '0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            z_valid     <= 1'b0;
            rd_conflict <= 1'b0;
        end else begin
            rd_conflict <= zif.Zlowout & zif.Zhighout;
            if (zif.cap_start) begin
                z_valid <= 1'b0;
            end else if (do_capture) begin
                zlow    <= zlow_d;
                zhigh   <= zhigh_d;
                flag_z  <= zif.Zero_in;
                flag_n  <= flag_n_d;
                z_valid <= 1'b1;
            end
        end
    end

`ifdef ZREG_OVF_FLAG_EN
    logic flag_v;
    logic flag_v_d;
    logic res_sign;

    assign res_sign = zif.ALUOut_in[DATA_W-1];

    // Signed overflow of add/sub from operand signs and the result sign
    always_comb begin
        flag_v_d = 1'b0;
        if (zif.ALUControl_in == OP_ADD) begin
            flag_v_d = (zif.A_sign == zif.B_sign) && (res_sign != zif.A_sign);
        end else if (zif.ALUControl_in == OP_SUB) begin
            flag_v_d = (zif.A_sign != zif.B_sign) && (res_sign != zif.A_sign);
        end
    end

    // Overflow flag captured alongside Z
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            flag_v <= 1'b0;
        end else if (do_capture && !zif.cap_start) begin
            flag_v <= flag_v_d;
        end
    end

    assign zif.flag_V = flag_v;
`endif

    // Read mux: low word wins when both strobes are asserted
    always_comb begin
        zif.bus_out = '0;
        if (zif.Zlowout) begin
            zif.bus_out = zlow;
        end else if (zif.Zhighout) begin
            zif.bus_out = zhigh;
        end
    end

    assign zif.ZLow_q      = zlow;
    assign zif.ZHigh_q     = zhigh;
    assign zif.flag_Z      = flag_z;
    assign zif.flag_N      = flag_n;
    assign zif.z_valid     = z_valid;
    assign zif.rd_conflict = rd_conflict;
    assign zif.busy        = (state == SETTLE) || (state == CAPTURE);

endmodule

// File: tb/tb_z_result_stage.sv
// Testbench for z_result_stage: vector table, corner sequences, randomized run
// against a deadline-based reference model.
module tb_z_result_stage;

    localparam int S = 3;

    logic clock = 1'b0;
    logic clear = 1'b1;

    z_result_stage_if #(.DATA_W(32)) zif ();

    z_result_stage #(
        .SETTLE_CYCLES(S),
        .DATA_W(32)
    ) dut (
        .clock(clock),
        .clear(clear),
        .zif(zif)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: Z contents plus the edge number at which a capture is due
    logic [31:0] m_zl;
    logic [31:0] m_zh;
    logic        m_fz;
    logic        m_fn;
    logic        m_fv;
    logic        m_valid;
    logic        m_rdc;
    int          deadline;
    int          cyc;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] alu;
        logic        zero;
        logic        as;
        logic        bs;
        logic [31:0] zl;
        logic [31:0] zh;
        logic        fn;
        logic        fz;
        logic        fv;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_zl     = '0;
        m_zh     = '0;
        m_fz     = 1'b0;
        m_fn     = 1'b0;
        m_fv     = 1'b0;
        m_valid  = 1'b0;
        m_rdc    = 1'b0;
        deadline = -1;
    endtask

    task automatic model_capture();
        logic [63:0] r;
        logic        a;
        logic        b;
        r = zif.ALUOut_in;
`ifdef ZREG_OVF_FLAG_EN
        a = zif.A_sign;
        b = zif.B_sign;
`else
        a = 1'b0;
        b = 1'b0;
`endif
        m_zl = r[31:0];
        if (zif.ALUControl_in == 4'b0111) begin
            m_zh = r[63:32];
            m_fn = r[63];
        end else if (zif.ALUControl_in == 4'b1010) begin
            m_zh = r[63:32];
            m_fn = r[31];
        end else begin
            m_zh = 32'h0;
            m_fn = r[31];
        end
        m_fz = zif.Zero_in;
        if (zif.ALUControl_in == 4'b0000)
            m_fv = (a == b) && (r[31] != a);
        else if (zif.ALUControl_in == 4'b0001)
            m_fv = (a != b) && (r[31] != a);
        else
            m_fv = 1'b0;
    endtask

    task automatic model_edge();
        cyc++;
        m_rdc = zif.Zlowout & zif.Zhighout;
        if (zif.cap_start) begin
            deadline = cyc + S + 1;
            m_valid  = 1'b0;
        end else if (deadline == cyc) begin
            model_capture();
            m_valid  = 1'b1;
            deadline = -1;
        end
    endtask

    function automatic logic [31:0] ref_bus();
        if (zif.Zlowout)
            return m_zl;
        else if (zif.Zhighout)
            return m_zh;
        return 32'h0;
    endfunction

    task automatic check_state();
        chk("zlow", zif.ZLow_q, m_zl);
        chk("zhigh", zif.ZHigh_q, m_zh);
        chk("flag_Z", zif.flag_Z, m_fz);
        chk("flag_N", zif.flag_N, m_fn);
        chk("z_valid", zif.z_valid, m_valid);
        chk("busy", zif.busy, deadline != -1);
        chk("rd_conflict", zif.rd_conflict, m_rdc);
`ifdef ZREG_OVF_FLAG_EN
        chk("flag_V", zif.flag_V, m_fv);
`endif
    endtask

    task automatic step();
        #1;
        chk("bus_out", zif.bus_out, ref_bus());
        @(posedge clock);
        model_edge();
        #1;
        check_state();
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [63:0] alu,
                           input logic zero, input logic as, input logic bs);
        zif.ALUControl_in = op;
        zif.ALUOut_in     = alu;
        zif.Zero_in       = zero;
`ifdef ZREG_OVF_FLAG_EN
        zif.A_sign = as;
        zif.B_sign = bs;
`else
        if (as || bs) begin
        end
`endif
    endtask

    task automatic run_vec(input vec_t v);
        set_alu(v.op, v.alu, v.zero, v.as, v.bs);
        zif.cap_start = 1'b1;
        step();
        zif.cap_start = 1'b0;
        repeat (S) step();
        chk("vec_valid_early", zif.z_valid, 1'b0);
        step();
        chk("vec_valid", zif.z_valid, 1'b1);
        chk("vec_zlow", zif.ZLow_q, v.zl);
        chk("vec_zhigh", zif.ZHigh_q, v.zh);
        chk("vec_flag_N", zif.flag_N, v.fn);
        chk("vec_flag_Z", zif.flag_Z, v.fz);
`ifdef ZREG_OVF_FLAG_EN
        chk("vec_flag_V", zif.flag_V, v.fv);
`endif
        zif.Zlowout = 1'b1;
        #1 chk("vec_rd_low", zif.bus_out, v.zl);
        zif.Zlowout  = 1'b0;
        zif.Zhighout = 1'b1;
        #1 chk("vec_rd_high", zif.bus_out, v.zh);
        zif.Zlowout = 1'b1;
        #1 chk("vec_rd_both", zif.bus_out, v.zl);
        step();
        chk("vec_conflict_pulse", zif.rd_conflict, 1'b1);
        zif.Zlowout  = 1'b0;
        zif.Zhighout = 1'b0;
        step();
        chk("vec_conflict_end", zif.rd_conflict, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] ops[5];

        vecs[0] = '{4'b0000, 64'h0000_0000_8000_0005, 1'b0, 1'b0, 1'b0,
                    32'h8000_0005, 32'h0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{4'b0111, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 1'b0, 1'b0,
                    32'hFFFF_FFF4, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'b1010, {32'd2, 32'd7}, 1'b0, 1'b0, 1'b0,
                    32'd7, 32'd2, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'b0011, 64'h0, 1'b1, 1'b0, 1'b0,
                    32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{4'b0001, 64'hDEAD_BEEF_8000_0000, 1'b0, 1'b0, 1'b0,
                    32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'b0001, 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b1, 1'b0,
                    32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{4'b0111, 64'h7000_0000_8000_0000, 1'b0, 1'b0, 1'b0,
                    32'h8000_0000, 32'h7000_0000, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{4'b1010, 64'hAAAA_0000_0000_0001, 1'b1, 1'b0, 1'b0,
                    32'h1, 32'hAAAA_0000, 1'b0, 1'b1, 1'b0};

        ops[0] = 4'b0000;
        ops[1] = 4'b0001;
        ops[2] = 4'b0111;
        ops[3] = 4'b1010;

        zif.cap_start = 1'b0;
        zif.Zlowout   = 1'b0;
        zif.Zhighout  = 1'b0;
        set_alu(4'b0000, 64'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        cyc = 0;

        #2;
        chk("reset_zlow", zif.ZLow_q, 32'h0);
        chk("reset_zhigh", zif.ZHigh_q, 32'h0);
        chk("reset_valid", zif.z_valid, 1'b0);
        chk("reset_busy", zif.busy, 1'b0);
        chk("reset_flags", {zif.flag_Z, zif.flag_N, zif.rd_conflict}, 3'b000);
        @(posedge clock);
        #1 clear = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Restart mid-settle: capture lands S+1 edges after the second start
        set_alu(4'b1010, {32'd2, 32'd7}, 1'b0, 1'b0, 1'b0);
        zif.cap_start = 1'b1;
        step();
        zif.cap_start = 1'b0;
        step();
        step();
        zif.ALUOut_in = {32'd4, 32'd9};
        zif.cap_start = 1'b1;
        step();
        zif.cap_start = 1'b0;
        repeat (S) step();
        chk("restart_valid_early", zif.z_valid, 1'b0);
        step();
        chk("restart_valid", zif.z_valid, 1'b1);
        chk("restart_zlow", zif.ZLow_q, 32'd9);
        chk("restart_zhigh", zif.ZHigh_q, 32'd4);

        // Reads during settle and in the start cycle return the old Z
        set_alu(4'b0111, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0);
        zif.Zhighout  = 1'b1;
        zif.cap_start = 1'b1;
        #1 chk("start_cycle_read", zif.bus_out, 32'd4);
        step();
        zif.cap_start = 1'b0;
        for (int i = 0; i < S; i++) begin
            chk("settle_read", zif.bus_out, 32'd4);
            step();
        end
        chk("settle_read_last", zif.bus_out, 32'd4);
        step();
        chk("post_capture_read", zif.bus_out, 32'h1234_5678);
        zif.Zhighout = 1'b0;

        // cap_start while in CAPTURE abandons that capture
        set_alu(4'b0000, 64'h5, 1'b0, 1'b0, 1'b0);
        zif.cap_start = 1'b1;
        step();
        zif.cap_start = 1'b0;
        repeat (S) step();
        zif.ALUOut_in = 64'h9;
        zif.cap_start = 1'b1;
        step();
        zif.cap_start = 1'b0;
        chk("abandon_zlow", zif.ZLow_q, 32'h9ABC_DEF0);
        chk("abandon_valid", zif.z_valid, 1'b0);
        repeat (S) step();
        chk("abandon_valid_early", zif.z_valid, 1'b0);
        step();
        chk("abandon_capture", zif.ZLow_q, 32'h9);

        // Asynchronous clear mid-settle
        set_alu(4'b0000, 64'h77, 1'b1, 1'b0, 1'b0);
        zif.cap_start = 1'b1;
        step();
        zif.cap_start = 1'b0;
        step();
        zif.Zlowout = 1'b1;
        #2 clear = 1'b1;
        #1;
        chk("clear_zlow", zif.ZLow_q, 32'h0);
        chk("clear_zhigh", zif.ZHigh_q, 32'h0);
        chk("clear_busy", zif.busy, 1'b0);
        chk("clear_valid", zif.z_valid, 1'b0);
        chk("clear_bus", zif.bus_out, 32'h0);
        chk("clear_flags", {zif.flag_Z, zif.flag_N}, 2'b00);
        model_reset();
        @(posedge clock);
        #1;
        chk("clear_hold_busy", zif.busy, 1'b0);
        clear       = 1'b0;
        zif.Zlowout = 1'b0;
        zif.cap_start = 1'b1;
        step();
        zif.cap_start = 1'b0;
        repeat (S) step();
        chk("post_clear_early", zif.z_valid, 1'b0);
        step();
        chk("post_clear_valid", zif.z_valid, 1'b1);
        chk("post_clear_zlow", zif.ZLow_q, 32'h77);
        chk("post_clear_flag_Z", zif.flag_Z, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            ops[4] = 4'($urandom);
            set_alu(ops[$urandom_range(0, 4)], {$urandom, $urandom},
                    1'($urandom), 1'($urandom), 1'($urandom));
            zif.cap_start = ($urandom_range(0, 5) == 0);
            zif.Zlowout   = 1'($urandom);
            zif.Zhighout  = 1'($urandom);
            step();
        end
        zif.cap_start = 1'b0;
        zif.Zlowout   = 1'b0;
        zif.Zhighout  = 1'b0;
        repeat (S + 2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
